// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serialises it onto a UART-style TX line
// (start bit, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA   = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP   = BW'(STOP_BITS - 1);
  localparam logic          ODD_INV     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             baud_tick;
  logic             can_start;

  assign baud_tick = (baud_q == '0);
  assign can_start = enable & ~empty;

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    parity_d = parity_q;

    unique case (state_q)
      IDLE:  if (can_start) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d  = rdata;
        parity_d = (^rdata) ^ ODD_INV;
        baud_d   = BAUD_RELOAD;
        bit_d    = '0;
        state_d  = START;
      end
      START: begin
        if (baud_tick) begin
          baud_d  = BAUD_RELOAD;
          state_d = DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          baud_d  = BAUD_RELOAD;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      PARITY: begin
        if (baud_tick) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = can_start ? FETCH : IDLE;
          end else begin
            bit_d  = bit_q + BW'(1);
            baud_d = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the state entry edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign rd_en      = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && baud_tick && (bit_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: four lanes with different framing parameters,
// a FIFO model per lane, and a cycle-accurate line receiver fed from a scoreboard queue.
module tb_fifo_uart_tx;

  localparam int NL = 4;
  localparam int CPB_L [NL] = '{4, 4, 4, 2};
  localparam int PE_L  [NL] = '{0, 1, 1, 0};
  localparam int PO_L  [NL] = '{0, 0, 1, 0};
  localparam int SB_L  [NL] = '{1, 1, 1, 2};

  typedef struct {
    int         lane;
    logic [7:0] word;
  } sb_t;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic [NL-1:0] enable_w = '0;
  logic [NL-1:0] empty_w;
  logic [NL-1:0] rd_en_w;
  logic [NL-1:0] tx_w;
  logic [NL-1:0] busy_w;
  logic [NL-1:0] done_w;
  logic [7:0]    rdata_r  [NL] = '{default: 8'h00};
  logic [7:0]    fifo_mem [NL][16];
  int            wr_ptr   [NL] = '{default: 0};
  int            rd_ptr   [NL] = '{default: 0};

  sb_t sb[$];
  int  gap_q[$];
  int  rd_cnt   [NL] = '{default: 0};
  int  done_cnt [NL] = '{default: 0};
  int  frames   [NL] = '{default: 0};
  int  par_seen [NL] = '{default: 9};
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign empty_w[g] = (wr_ptr[g] == rd_ptr[g]);
    fifo_uart_tx #(
      .WIDTH(8), .CLKS_PER_BIT(CPB_L[g]), .PARITY_EN(PE_L[g]),
      .PARITY_ODD(PO_L[g]), .STOP_BITS(SB_L[g])
    ) u_dut (
      .clk(clk), .res(res), .enable(enable_w[g]), .empty(empty_w[g]),
      .rdata(rdata_r[g]), .rd_en(rd_en_w[g]), .tx(tx_w[g]),
      .busy(busy_w[g]), .frame_done(done_w[g])
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] w);
    fifo_mem[lane][wr_ptr[lane] % 16] = w;
    wr_ptr[lane] = wr_ptr[lane] + 1;
    sb.push_back('{lane, w});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lane);
    int n;
    n = 0;
    while (!busy_w[lane] && n < 10) begin tick(1); n++; end
    check($sformatf("L%0d start_timeout", lane), int'(busy_w[lane]), 1);
    n = 0;
    while (busy_w[lane] && n < 500) begin tick(1); n++; end
    check($sformatf("L%0d idle_timeout", lane), int'(busy_w[lane]), 0);
  endtask

  // FIFO read port: data registered on the edge where rd_en=1 and empty=0.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rd_en_w[i] && !empty_w[i]) begin
        rdata_r[i] <= fifo_mem[i][rd_ptr[i] % 16];
        rd_ptr[i]  <= rd_ptr[i] + 1;
      end
    end
  end

  // Line receiver: every frame cycle is compared against the frame built from the scoreboard word.
  logic [15:0] bits_l [NL];
  int          len_l  [NL];
  int          k_l    [NL];
  int          gapc   [NL];
  logic        active [NL] = '{default: 1'b0};
  logic        pend   [NL] = '{default: 1'b0};
  logic        prev_rd[NL] = '{default: 1'b0};

  always @(negedge clk) begin
    sb_t         e;
    logic [15:0] fb;
    for (int i = 0; i < NL; i++) begin
      if (res) begin
        active[i]  = 1'b0;
        pend[i]    = 1'b0;
        prev_rd[i] = 1'b0;
      end else begin
        if (rd_en_w[i]) begin
          check($sformatf("L%0d rd_en_width", i), int'(prev_rd[i]), 0);
          check($sformatf("L%0d underflow", i), int'(empty_w[i]), 0);
          rd_cnt[i]++;
        end
        prev_rd[i] = rd_en_w[i];
        if (done_w[i]) done_cnt[i]++;
        if (!active[i]) begin
          if (!tx_w[i]) begin
            gap_q.push_back(pend[i] ? gapc[i] : -1);
            pend[i] = 1'b0;
            e = '{-1, 8'h00};
            if (sb.size() > 0) e = sb.pop_front();
            check($sformatf("L%0d sb_lane", i), e.lane, i);
            fb    = '1;
            fb[0] = 1'b0;
            for (int j = 0; j < 8; j++) fb[1+j] = e.word[j];
            if (PE_L[i] != 0) fb[9] = (^e.word) ^ (PO_L[i] != 0);
            bits_l[i] = fb;
            len_l[i]  = (9 + PE_L[i] + SB_L[i]) * CPB_L[i];
            k_l[i]    = 0;
            active[i] = 1'b1;
          end else if (pend[i]) begin
            gapc[i]++;
          end
        end
        if (active[i]) begin
          check($sformatf("L%0d tx k=%0d", i, k_l[i]), int'(tx_w[i]),
                int'(bits_l[i][k_l[i] / CPB_L[i]]));
          check($sformatf("L%0d frame_done k=%0d", i, k_l[i]), int'(done_w[i]),
                int'(k_l[i] == len_l[i] - 1));
          if (PE_L[i] != 0 && k_l[i] == 9 * CPB_L[i] + CPB_L[i] / 2) par_seen[i] = int'(tx_w[i]);
          k_l[i]++;
          if (k_l[i] == len_l[i]) begin
            active[i] = 1'b0;
            pend[i]   = 1'b1;
            gapc[i]   = 0;
            frames[i]++;
          end
        end else if (done_w[i]) begin
          check($sformatf("L%0d stray_done", i), 1, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall, bcnt, run, off, r0, f0, g0, quiet;
    logic [9:0] seq;

    // Reset state on every lane.
    tick(3);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("L%0d rst_tx", i), int'(tx_w[i]), 1);
      check($sformatf("L%0d rst_busy", i), int'(busy_w[i]), 0);
      check($sformatf("L%0d rst_rd_en", i), int'(rd_en_w[i]), 0);
      check($sformatf("L%0d rst_done", i), int'(done_w[i]), 0);
    end
    res = 1'b0;
    tick(2);

    // Single 0xA5 frame: latency, busy length, bit sequence, one pop, one done.
    r0 = rd_cnt[0];
    f0 = done_cnt[0];
    push(0, 8'hA5);
    enable_w[0] = 1'b1;
    fall = -1; bcnt = 0; seq = '0;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (fall < 0 && !tx_w[0]) fall = i;
      if (fall >= 0 && (i - fall) % 4 == 1 && (i - fall) / 4 < 10) seq[(i - fall) / 4] = tx_w[0];
      if (busy_w[0]) bcnt++;
      if (bcnt > 0 && !busy_w[0]) break;
    end
    check("a5_latency", fall, 3);
    check("a5_busy_cycles", bcnt, 42);
    check("a5_bit_seq", int'(seq), int'(10'b1101001010));
    check("a5_rd_pulses", rd_cnt[0] - r0, 1);
    check("a5_done_pulses", done_cnt[0] - f0, 1);

    // Parity: even 0xA5 -> 0, odd 0x07 -> 0, odd 0xA5 -> 1.
    enable_w[1] = 1'b1;
    push(1, 8'hA5);
    wait_idle(1);
    check("par_even_a5", par_seen[1], 0);
    enable_w[2] = 1'b1;
    push(2, 8'h07);
    wait_idle(2);
    check("par_odd_07", par_seen[2], 0);
    push(2, 8'hA5);
    wait_idle(2);
    check("par_odd_a5", par_seen[2], 1);

    // Back-to-back frames separated by FETCH and LOAD.
    r0 = rd_cnt[0];
    f0 = frames[0];
    g0 = gap_q.size();
    push(0, 8'h01);
    push(0, 8'h80);
    push(0, 8'hFF);
    wait_idle(0);
    check("b2b_rd_pulses", rd_cnt[0] - r0, 3);
    check("b2b_frames", frames[0] - f0, 3);
    check("b2b_gap1", (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -2, 2);
    check("b2b_gap2", (gap_q.size() > g0 + 2) ? gap_q[g0 + 2] : -2, 2);

    // enable low holds off the fetch; raising it starts a frame 3 cycles later.
    enable_w[0] = 1'b0;
    r0 = rd_cnt[0];
    push(0, 8'h3C);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!tx_w[0] || busy_w[0]) quiet++;
    end
    check("dis_quiet", quiet, 0);
    check("dis_no_rd", rd_cnt[0] - r0, 0);
    enable_w[0] = 1'b1;
    fall = -1;
    for (int i = 1; i <= 10 && fall < 0; i++) begin
      tick(1);
      if (!tx_w[0]) fall = i;
    end
    check("en_latency", fall, 3);
    // Drop enable during DATA with another word waiting.
    tick(6);
    push(0, 8'h55);
    enable_w[0] = 1'b0;
    wait_idle(0);
    tick(10);
    check("en_drop_rd", rd_cnt[0] - r0, 1);
    check("en_drop_busy", int'(busy_w[0]), 0);

    // Asynchronous reset in the middle of DATA of 0x55; 0xC3 must follow intact.
    push(0, 8'hC3);
    enable_w[0] = 1'b1;
    fall = -1;
    for (int i = 1; i <= 10 && fall < 0; i++) begin
      tick(1);
      if (!tx_w[0]) fall = i;
    end
    check("rst_pre_latency", fall, 3);
    tick(12);
    check("rst_pre_busy", int'(busy_w[0]), 1);
    #2 res = 1'b1;
    #1;
    check("arst_tx", int'(tx_w[0]), 1);
    check("arst_busy", int'(busy_w[0]), 0);
    check("arst_rd_en", int'(rd_en_w[0]), 0);
    check("arst_done", int'(done_w[0]), 0);
    @(posedge clk);
    #1 res = 1'b0;
    r0 = rd_cnt[0];
    f0 = frames[0];
    wait_idle(0);
    check("post_rst_rd", rd_cnt[0] - r0, 1);
    check("post_rst_frames", frames[0] - f0, 1);

    // Two stop bits at 2 clocks per bit: 4-cycle stop phase, 22-cycle frame.
    enable_w[3] = 1'b1;
    push(3, 8'h16);
    fall = -1; run = 0; off = -1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (fall < 0 && !tx_w[3]) fall = i;
      if (fall >= 0) begin
        run = tx_w[3] ? run + 1 : 0;
        if (done_w[3]) begin
          off = i - fall + 1;
          break;
        end
      end
    end
    check("s2_latency", fall, 3);
    check("s2_frame_len", off, 22);
    check("s2_stop_run", run, 4);
    wait_idle(3);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
